// File: rtl/dtcm_arb_pkg.sv
// Shared types and width constants for the DTCM arbiter.
//   arb_state_t : starvation FSM states (CPU priority / forced DMA slot)
//   owner_t     : who issued the read whose data returns next cycle
package dtcm_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic {
        CPU_PRI,
        DMA_FORCE
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_DMA
    } owner_t;

endpackage

// File: rtl/dtcm_arb_starve.sv
// Starvation guard for the DMA master of the DTCM arbiter.
// Counts consecutive cycles a DMA request loses arbitration; once the count reaches
// MAX_WAIT the next cycle is handed to the DMA (force_dma=1) for exactly one access.
// Ports:
//   clk, reset : core clock, synchronous active-high reset
//   dma_req    : DMA request pending
//   dma_gnt    : DMA granted this cycle
//   force_dma  : registered, high while the FSM is in DMA_FORCE
module dtcm_arb_starve
    import dtcm_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic dma_req,
    input  logic dma_gnt,
    output logic force_dma
);

    arb_state_t state_q;
    logic [3:0] wait_cnt_q;
    logic [3:0] wait_cnt_d;

    // A lost cycle extends the streak; a grant or a withdrawn request ends it.
    always_comb begin
        wait_cnt_d = '0;
        if (dma_req && !dma_gnt) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CPU_PRI;
            wait_cnt_q <= '0;
            force_dma  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            case (state_q)
                CPU_PRI: begin
                    if (wait_cnt_d == 4'(MAX_WAIT)) begin
                        state_q   <= DMA_FORCE;
                        force_dma <= 1'b1;
                    end
                end
                DMA_FORCE: begin
                    // The forced slot is a single cycle whether or not the DMA used it.
                    state_q   <= CPU_PRI;
                    force_dma <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dtcm_arbiter.sv
// Single-port DTCM arbiter between the CPU memory-access stage and a DMA master.
// The CPU has priority; dtcm_arb_starve forces a one-cycle DMA slot (stalling the CPU)
// after MAX_WAIT lost cycles. Grants are combinational; read data returns one cycle later.
// Ports:
//   clk, reset                              : core clock, synchronous active-high reset
//   cpu_en/wen/addr/wdata, cpu_rdata        : CPU access request and read data
//   cpu_stall                               : CPU request not taken this cycle
//   dma_req/wen/addr/wdata, dma_gnt         : DMA request and acceptance
//   dma_rdata, dma_rvalid                   : DMA read return
//   mem_en/wen/addr/wdata, mem_rdata        : arbitrated memory side (sync read)
module dtcm_arbiter
    import dtcm_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_en,
    input  logic [BE_W-1:0]   cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic [BE_W-1:0]   dma_wen,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic              mem_en,
    output logic [BE_W-1:0]   mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic   force_dma;
    logic   cpu_win;
    logic   dma_win;
    owner_t rd_owner_q;
    owner_t rd_owner_d;

    dtcm_arb_starve #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk       (clk),
        .reset     (reset),
        .dma_req   (dma_req),
        .dma_gnt   (dma_gnt),
        .force_dma (force_dma)
    );

    always_comb begin
        dma_win   = dma_req && (force_dma || !cpu_en);
        cpu_win   = cpu_en && !dma_win;
        cpu_stall = cpu_en && dma_win;
        dma_gnt   = dma_win;

        // Byte enables come only from the winner, so a stalled CPU write never lands.
        mem_en    = cpu_win || dma_win;
        mem_wen   = '0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (dma_win) begin
            mem_wen   = dma_wen;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end else if (cpu_win) begin
            mem_wen = cpu_wen;
        end

        rd_owner_d = OWN_NONE;
        if (dma_win && (dma_wen == '0)) begin
            rd_owner_d = OWN_DMA;
        end else if (cpu_win && (cpu_wen == '0)) begin
            rd_owner_d = OWN_CPU;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_owner_q <= OWN_NONE;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    assign cpu_rdata  = mem_rdata;
    assign dma_rdata  = mem_rdata;
    // Masked during reset so a read return in flight is dropped immediately.
    assign dma_rvalid = (rd_owner_q == OWN_DMA) && !reset;

endmodule

// File: tb/tb_dtcm_arbiter.sv
module tb_dtcm_arbiter;

    localparam int unsigned MW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dma_req;
    logic [3:0]  dma_wen;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_gnt, dma_rvalid;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    dtcm_arbiter #(.MAX_WAIT(MW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_en     (cpu_en),
        .cpu_wen    (cpu_wen),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dma_req    (dma_req),
        .dma_wen    (dma_wen),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rdata  (dma_rdata),
        .dma_rvalid (dma_rvalid),
        .mem_en     (mem_en),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous DTCM behind the arbiter, with a bench-side preload port.
    logic [31:0] mem [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = 8'h0;
    logic [31:0] pl_data = 32'h0;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wen[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            mem_rdata <= mem[mem_addr[9:2]];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_en = 0; cpu_wen = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_wen = 0; dma_addr = 0; dma_wdata = 0;
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        pl_en = 1; pl_idx = addr[9:2]; pl_data = data;
        tick();
        pl_en = 0;
    endtask

    typedef struct {
        logic       cpu_en;
        logic [3:0] cpu_wen;
        logic       dma_req;
        logic [3:0] dma_wen;
        logic       exp_stall;
        logic       exp_gnt;
        logic       exp_en;
        logic [3:0] exp_wen;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vt [10];

    // Reference model state for the random phase
    bit          refused_hist [$];
    logic [31:0] ref_mem [0:255];
    logic [3:0]  wen_tab [5];
    int          run;
    logic        forced, e_gnt, e_stall, e_cpu, e_en;
    logic [3:0]  e_wen;
    logic [31:0] e_addr, e_wdata;
    logic        prev_cpu_rd, prev_dma_rd, prev_stall, prev_gnt;
    logic [31:0] prev_cpu_data, prev_dma_data;

    initial begin
        reset = 1;
        idle();
        for (int i = 0; i < 256; i++) preload(32'(i) << 2, 32'h0);
        preload(32'h10, 32'h12345678);
        preload(32'h40, 32'h0000BEEF);
        preload(32'h300, 32'hAAAA5555);
        tick();
        reset = 0;

        // Reset state
        @(negedge clk);
        chk("reset_rvalid", 32'(dma_rvalid), 32'h0);
        chk("reset_gnt", 32'(dma_gnt), 32'h0);
        chk("reset_stall", 32'(cpu_stall), 32'h0);
        chk("reset_mem_en", 32'(mem_en), 32'h0);
        chk("reset_mem_wen", 32'(mem_wen), 32'h0);
        tick();

        // Table: CPU at 0x100, DMA at 0x200, starting from CPU_PRI with an empty streak.
        vt[0] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0};
        vt[1] = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0, 32'h100};
        vt[2] = '{1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 1'b1, 1'b1, 4'hF, 32'h200};
        vt[3] = '{1'b1, 4'h3, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 4'h3, 32'h100};
        vt[4] = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0, 32'h100};
        vt[5] = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0, 32'h100};
        vt[6] = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0, 32'h100};
        vt[7] = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 4'h0, 32'h200};
        vt[8] = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hF, 32'h100};
        vt[9] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0};
        for (int i = 0; i < 10; i++) begin
            cpu_en = vt[i].cpu_en; cpu_wen = vt[i].cpu_wen;
            cpu_addr = 32'h100; cpu_wdata = 32'h0;
            dma_req = vt[i].dma_req; dma_wen = vt[i].dma_wen;
            dma_addr = 32'h200; dma_wdata = 32'h5A5A0000;
            @(negedge clk);
            chk($sformatf("tab%0d_stall", i), 32'(cpu_stall), 32'(vt[i].exp_stall));
            chk($sformatf("tab%0d_gnt", i), 32'(dma_gnt), 32'(vt[i].exp_gnt));
            chk($sformatf("tab%0d_en", i), 32'(mem_en), 32'(vt[i].exp_en));
            chk($sformatf("tab%0d_wen", i), 32'(mem_wen), 32'(vt[i].exp_wen));
            if (vt[i].exp_en) chk($sformatf("tab%0d_addr", i), mem_addr, vt[i].exp_addr);
            tick();
        end
        idle();

        // CPU-only read
        cpu_en = 1; cpu_addr = 32'h10;
        @(negedge clk);
        chk("cpu_rd_en", 32'(mem_en), 32'h1);
        chk("cpu_rd_stall", 32'(cpu_stall), 32'h0);
        tick();
        idle();
        @(negedge clk);
        chk("cpu_rd_data", cpu_rdata, 32'h12345678);
        tick();

        // DMA-only write, then CPU reads it back
        dma_req = 1; dma_wen = 4'hF; dma_addr = 32'h20; dma_wdata = 32'hCAFEBABE;
        @(negedge clk);
        chk("dma_wr_gnt", 32'(dma_gnt), 32'h1);
        chk("dma_wr_wen", 32'(mem_wen), 32'hF);
        tick();
        idle();
        cpu_en = 1; cpu_addr = 32'h20;
        @(negedge clk);
        chk("cpu_rb_stall", 32'(cpu_stall), 32'h0);
        tick();
        idle();
        @(negedge clk);
        chk("cpu_rb_data", cpu_rdata, 32'hCAFEBABE);
        tick();

        // Continuous contention: DMA forced on every 5th cycle, CPU write masked there
        cpu_en = 1; cpu_wen = 4'hF; cpu_addr = 32'h300; cpu_wdata = 32'hDEADDEAD;
        dma_req = 1; dma_wen = 4'h0; dma_addr = 32'h80;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            chk($sformatf("cont%0d_gnt", c), 32'(dma_gnt), 32'((c % 5) == 0));
            chk($sformatf("cont%0d_stall", c), 32'(cpu_stall), 32'((c % 5) == 0));
            if ((c % 5) == 0) chk($sformatf("cont%0d_wen", c), 32'(mem_wen), 32'h0);
            tick();
        end
        idle();
        tick();

        // DMA read return
        dma_req = 1; dma_addr = 32'h40;
        @(negedge clk);
        chk("dma_rd_gnt", 32'(dma_gnt), 32'h1);
        tick();
        idle();
        @(negedge clk);
        chk("dma_rd_rvalid", 32'(dma_rvalid), 32'h1);
        chk("dma_rd_data", dma_rdata, 32'h0000BEEF);
        tick();
        @(negedge clk);
        chk("dma_rd_rvalid_off", 32'(dma_rvalid), 32'h0);
        tick();

        // Withdrawal under CPU load, then the streak must restart from zero
        cpu_en = 1; cpu_addr = 32'h10;
        dma_req = 1; dma_wen = 4'hF; dma_addr = 32'h44; dma_wdata = 32'h11111111;
        for (int c = 0; c < 5; c++) begin
            if (c == 3) dma_req = 0;
            @(negedge clk);
            chk($sformatf("wd%0d_gnt", c), 32'(dma_gnt), 32'h0);
            chk($sformatf("wd%0d_stall", c), 32'(cpu_stall), 32'h0);
            chk($sformatf("wd%0d_wen", c), 32'(mem_wen), 32'h0);
            tick();
        end
        dma_req = 1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("wd_re%0d_gnt", c), 32'(dma_gnt), 32'(c == 5));
            tick();
        end
        idle();
        tick();

        // Reset in the cycle after a granted DMA read
        dma_req = 1; dma_addr = 32'h40;
        @(negedge clk);
        chk("rst_rd_gnt", 32'(dma_gnt), 32'h1);
        tick();
        idle();
        reset = 1;
        @(negedge clk);
        chk("rst_rvalid_during", 32'(dma_rvalid), 32'h0);
        tick();
        reset = 0;
        @(negedge clk);
        chk("rst_rvalid_after", 32'(dma_rvalid), 32'h0);
        tick();

        // Reset on the cycle that would arm the forced slot: FSM must stay in CPU_PRI
        cpu_en = 1; cpu_addr = 32'h10; dma_req = 1; dma_addr = 32'h40;
        for (int c = 1; c <= 5; c++) begin
            reset = (c == 4);
            @(negedge clk);
            if (c == 5) begin
                chk("rst_force_stall", 32'(cpu_stall), 32'h0);
                chk("rst_force_gnt", 32'(dma_gnt), 32'h0);
            end
            tick();
        end
        reset = 1;
        idle();
        tick();
        tick();
        reset = 0;

        // Randomized phase against the reference model
        wen_tab = '{4'h0, 4'hF, 4'h1, 4'hC, 4'h3};
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        refused_hist.delete();
        prev_cpu_rd = 0; prev_dma_rd = 0; prev_stall = 0; prev_gnt = 0;
        prev_cpu_data = 0; prev_dma_data = 0;
        for (int n = 0; n < 400; n++) begin
            if (!prev_stall) begin
                cpu_en    = ($urandom_range(0, 9) < 7);
                cpu_wen   = wen_tab[$urandom_range(0, 4)];
                cpu_addr  = 32'($urandom_range(0, 63)) << 2;
                cpu_wdata = $urandom;
            end
            if (dma_req && !prev_gnt) begin
                if ($urandom_range(0, 9) == 0) dma_req = 0;
            end else begin
                dma_req   = ($urandom_range(0, 9) < 4);
                dma_wen   = wen_tab[$urandom_range(0, 4)];
                dma_addr  = 32'($urandom_range(0, 63)) << 2;
                dma_wdata = $urandom;
            end

            // DMA is forced once it has lost MAX_WAIT cycles in a row.
            run = 0;
            for (int k = refused_hist.size() - 1; k >= 0; k--) begin
                if (!refused_hist[k]) break;
                run++;
            end
            forced  = (run == MW);
            e_gnt   = dma_req && (forced || !cpu_en);
            e_stall = cpu_en && e_gnt;
            e_cpu   = cpu_en && !e_gnt;
            e_en    = e_gnt || e_cpu;
            e_wen   = e_gnt ? dma_wen : (e_cpu ? cpu_wen : 4'h0);
            e_addr  = e_gnt ? dma_addr : cpu_addr;
            e_wdata = e_gnt ? dma_wdata : cpu_wdata;

            @(negedge clk);
            chk("rnd_gnt", 32'(dma_gnt), 32'(e_gnt));
            chk("rnd_stall", 32'(cpu_stall), 32'(e_stall));
            chk("rnd_en", 32'(mem_en), 32'(e_en));
            chk("rnd_wen", 32'(mem_wen), 32'(e_wen));
            if (e_en) begin
                chk("rnd_addr", mem_addr, e_addr);
                chk("rnd_wdata", mem_wdata, e_wdata);
            end
            chk("rnd_rvalid", 32'(dma_rvalid), 32'(prev_dma_rd));
            if (prev_dma_rd) chk("rnd_dma_rdata", dma_rdata, prev_dma_data);
            if (prev_cpu_rd) chk("rnd_cpu_rdata", cpu_rdata, prev_cpu_data);

            prev_cpu_rd   = e_cpu && (cpu_wen == 4'h0);
            prev_dma_rd   = e_gnt && (dma_wen == 4'h0);
            prev_cpu_data = ref_mem[e_addr[9:2]];
            prev_dma_data = ref_mem[e_addr[9:2]];
            if (e_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (e_wen[b]) ref_mem[e_addr[9:2]][8*b +: 8] = e_wdata[8*b +: 8];
                end
            end
            refused_hist.push_back(dma_req && !e_gnt);
            if (refused_hist.size() > 16) void'(refused_hist.pop_front());
            prev_stall = e_stall;
            prev_gnt   = e_gnt;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dtcm_arbiter.md
# dtcm_arbiter

Arbitrates the single-port data TCM between the CPU memory-access stage and a second bus master (DMA/program loader). The CPU has priority. A starvation counter guarantees the second master a slot within a bounded number of cycles by stalling the CPU for one cycle. The block sits between the memory-access stage and the DTCM/GPIO address decode, which keeps operating on the arbitrated memory-side signals.

## Interface
- MAX_WAIT, 4: cycles a pending DMA request may lose arbitration before it is forced through (1..15).
- clk  in  1  core clock; everything is sampled on the rising edge.
- reset  in  1  synchronous, active-high.
- cpu_en  in  1  CPU access request this cycle.
- cpu_wen  in  4  CPU byte write enables; 0 means read.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU write data.
- cpu_rdata  out  32  CPU read data, valid the cycle after the CPU read is granted.
- cpu_stall  out  1  CPU access not taken this cycle; CPU holds its request unchanged.
- dma_req  in  1  DMA access request; held until dma_gnt.
- dma_wen  in  4  DMA byte write enables; 0 means read.
- dma_addr  in  32  DMA byte address.
- dma_wdata  in  32  DMA write data.
- dma_gnt  out  1  DMA request accepted this cycle.
- dma_rdata  out  32  DMA read data, qualified by dma_rvalid.
- dma_rvalid  out  1  DMA read data valid (cycle after a granted DMA read).
- mem_en  out  1  memory-side access strobe.
- mem_wen  out  4  memory-side byte enables.
- mem_addr  out  32  memory-side address.
- mem_wdata  out  32  memory-side write data.
- mem_rdata  in  32  memory read data, synchronous, one cycle after mem_en.

## Operation
- Grant decision is combinational each cycle from cpu_en, dma_req and the FSM state.
- State CPU_PRI (reset state):
  - cpu_en=1: the CPU wins, cpu_stall=0, dma_gnt=0.
  - cpu_en=0 and dma_req=1: the DMA wins, dma_gnt=1.
- State DMA_FORCE: if dma_req=1, the DMA wins and dma_gnt=1. If cpu_en=1 in that cycle, cpu_stall=1.
- wait_cnt (4 bits):
  - increments each cycle that dma_req=1 and dma_gnt=0.
  - clears on dma_gnt or when dma_req=0.
- Transitions:
  - CPU_PRI -> DMA_FORCE when the next wait_cnt value equals MAX_WAIT.
  - DMA_FORCE -> CPU_PRI unconditionally after one cycle. A forced grant lasts exactly one access.
- Memory-side mux selects the winner's en/wen/addr/wdata. With no winner: mem_en=0 and mem_wen=0.
- A loser's mem_wen is never driven. A stalled CPU write must not reach memory.
- rd_owner register (CPU/DMA/none) records who issued a granted read (wen=0). It steers the next cycle's mem_rdata.
- cpu_rdata = mem_rdata, unconditionally. The CPU consumes it only after its own granted read.
- dma_rdata = mem_rdata. dma_rvalid = (rd_owner == DMA).
- The arbiter does no address decode. GPIO-region addresses pass through like any other, whichever master wins.
- A DMA request that drops without being granted is legal. It clears wait_cnt with no side effects.

## Timing
- Reset values: state=CPU_PRI, wait_cnt=0, rd_owner=none. Consequently dma_rvalid=0, dma_gnt=0, cpu_stall=0, mem_en=0.
- Grant and stall: zero cycles latency (same cycle as the request).
- Read data: one cycle after the grant.
- Back-to-back granted reads are supported every cycle.
- Under continuous cpu_en and dma_req, the DMA is granted every MAX_WAIT+1 cycles.
- Reset asserted mid-operation: a pending dma_rvalid is suppressed in the following cycle, and the FSM returns to CPU_PRI.
- dma_req arriving in the same cycle the FSM enters DMA_FORCE: no special case; the decision follows the state rules.

## Structure
- Shared package dtcm_arb_pkg:
  - arb_state_t enum: CPU_PRI, DMA_FORCE.
  - owner_t enum: OWN_NONE, OWN_CPU, OWN_DMA.
  - Width constants: ADDR_W=32, DATA_W=32, BE_W=4.
- The request mux and the read-return steering stay inline.
- One natural sub-module: dtcm_arb_starve. It holds wait_cnt and the FSM, and outputs force_dma.

## Test plan
- CPU only: cpu_en=1 read 0x00000010, DTCM holds 0x12345678 -> mem_en=1 the same cycle; cpu_rdata=0x12345678 next cycle; cpu_stall never asserts.
- DMA only: dma_req=1, dma_wen=4'hF, addr 0x20, data 0xCAFEBABE -> dma_gnt same cycle; a later CPU read of 0x20 returns 0xCAFEBABE.
- Contention, MAX_WAIT=4: cpu_en and dma_req both held high -> dma_gnt=1 and cpu_stall=1 in cycle 5 only. Repeats every 5 cycles; the stalled CPU write does not reach memory.
- DMA read return: granted DMA read of 0x40 = 0x0000BEEF -> dma_rvalid=1 with dma_rdata=0x0000BEEF one cycle later; next cycle dma_rvalid=0.
- Request withdrawal: dma_req high for 3 cycles under CPU load, then low -> wait_cnt=0; no gnt, stall or write.
- Reset mid-read: assert reset in the cycle after a granted DMA read -> dma_rvalid=0, and FSM in CPU_PRI after reset.
